// File: rtl/data_memory_responder_if.sv
// ---------------------------------------------------------------------------
// data_memory_responder_if
// Load/store handshake between the control unit / DataFlow (master) and the
// data memory responder (slave).
//   memory_start      master -> slave  request, held until memory_done is seen
//   sel_mem_operation master -> slave  1 = store, 0 = load
//   address           master -> slave  64-bit byte address
//   write_data        master -> slave  store data (low bytes used)
//   funct3            master -> slave  [1:0] size, [2] unsigned load
//   memory_done       slave -> master  one-cycle completion pulse
//   read_data         slave -> master  extended load result
//   misaligned        slave -> master  alignment error for completed request
//   busy              slave -> master  responder not idle
// ---------------------------------------------------------------------------
interface data_memory_responder_if;
  logic        memory_start;
  logic        sel_mem_operation;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [2:0]  funct3;
  logic        memory_done;
  logic [63:0] read_data;
  logic        misaligned;
  logic        busy;

  modport master (
    output memory_start, sel_mem_operation, address, write_data, funct3,
    input  memory_done, read_data, misaligned, busy
  );

  modport slave (
    input  memory_start, sel_mem_operation, address, write_data, funct3,
    output memory_done, read_data, misaligned, busy
  );
endinterface

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
// Responder end of the RV64 load/store handshake. A request is captured in
// IDLE, optionally delayed by LATENCY wait cycles, then performed as a single
// byte/half/word/double access on an internal doubleword-wide RAM, and
// finished with a one-cycle memory_done pulse.
//   clk    posedge clock
//   rst_n  synchronous active-low reset (RAM contents are kept)
//   bus    slave side of data_memory_responder_if
// Parameters:
//   MEM_ADDR_BITS  log2 of RAM depth in 64-bit doublewords
//   LATENCY        wait cycles before the access (0 skips WAIT)
// ---------------------------------------------------------------------------
module data_memory_responder #(
  parameter int MEM_ADDR_BITS = 9,
  parameter int LATENCY       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  data_memory_responder_if.slave  bus
);

  localparam int ADDR_W = MEM_ADDR_BITS + 3;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAST   = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACCESS, S_DONE, S_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                store_q, store_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [2:0]          f3_q, f3_d;
  logic                done_q, done_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                mis_q, mis_d;
  logic                busy_q, busy_d;

  logic [63:0]         mem [0:(1<<MEM_ADDR_BITS)-1];
  logic                mem_we;
  logic [63:0]         mem_wdata;

  logic [MEM_ADDR_BITS-1:0] idx;
  logic [2:0]          offset;
  logic [1:0]          size;
  logic [63:0]         word;
  logic [63:0]         shifted;
  logic                mis_calc;
  logic [63:0]         load_val;
  logic [7:0]          lanes;
  logic [7:0]          lanes_sh;
  logic [63:0]         bit_mask;
  logic [63:0]         wdata_sh;

  // Address bits above the RAM size are dropped so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.address[63:ADDR_W];

  assign bus.memory_done = done_q;
  assign bus.read_data   = rdata_q;
  assign bus.misaligned  = mis_q;
  assign bus.busy        = busy_q;

  // Access datapath: decode the captured request, extract/extend load data
  // and merge store bytes into the addressed doubleword.
  always_comb begin
    idx      = addr_q[ADDR_W-1:3];
    offset   = addr_q[2:0];
    size     = f3_q[1:0];
    word     = mem[idx];
    shifted  = word >> {offset, 3'b000};
    mis_calc = 1'b0;
    load_val = 64'd0;
    lanes    = 8'h00;
    bit_mask = 64'd0;
    case (size)
      2'd0: begin
        lanes    = 8'h01;
        load_val = f3_q[2] ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        lanes    = 8'h03;
        mis_calc = offset[0];
        load_val = f3_q[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      2'd2: begin
        lanes    = 8'h0F;
        mis_calc = (offset[1:0] != 2'd0);
        load_val = f3_q[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        lanes    = 8'hFF;
        mis_calc = (offset != 3'd0);
        load_val = shifted;
      end
    endcase
    lanes_sh = lanes << offset;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{lanes_sh[i]}};
    end
    wdata_sh  = wdata_q << {offset, 3'b000};
    mem_wdata = (word & ~bit_mask) | (wdata_sh & bit_mask);
  end

  // Handshake FSM. IDLE first registers the request (pend_q) and only leaves
  // on the following edge, so DONE starts LATENCY+2 edges after the start is
  // sampled; the captured fields are frozen once pend_q is set.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!pend_q) begin
          if (bus.memory_start) begin
            pend_d  = 1'b1;
            store_d = bus.sel_mem_operation;
            addr_d  = bus.address[ADDR_W-1:0];
            wdata_d = bus.write_data;
            f3_d    = bus.funct3;
          end
        end else begin
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = (LATENCY == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        mis_d   = mis_calc;
        if (mis_calc) begin
          rdata_d = 64'd0;
        end else if (store_q) begin
          mem_we = 1'b1;
        end else begin
          rdata_d = load_val;
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!bus.memory_start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 64'd0;
      f3_q    <= 3'd0;
      done_q  <= 1'b0;
      rdata_q <= 64'd0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
    end
  end

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= mem_wdata;
    end
  end

endmodule
